// File: rtl/pc_pkg.sv
// Shared types and constants for the pc_counter16 program counter.
package pc_pkg;

    typedef logic [15:0] addr_t;

    localparam addr_t PC_RESET_ADDR = 16'h0000;

    typedef enum logic [2:0] {
        NXT_HOLD,
        NXT_INC,
        NXT_LOAD,
        NXT_CALL,
        NXT_RET
    } nxt_sel_e;

endpackage

// File: rtl/Inc16.sv
// Hack-style 16-bit incrementer: out = in + 1, wrapping at 0xFFFF.
module Inc16 (
    input  logic [15:0] in,
    output logic [15:0] out
);
    assign out = in + 16'd1;
endmodule

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack: DEPTH x 16 entries with empty/full flags
// and a sticky overflow/underflow error flag; synchronous active-high reset.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  addr_t push_data_i,
    output addr_t top_o,
    output logic  empty_o,
    output logic  full_o,
    output logic  err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    addr_t         mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic          do_push;
    logic [IW-1:0] top_idx;

    // Pop has priority; a pop on empty or a push on full only raises err.
    always_comb begin
        ptr_d   = ptr_q;
        err_d   = err_q;
        do_push = 1'b0;
        if (pop_i) begin
            if (empty_q) err_d = 1'b1;
            else         ptr_d = ptr_q - PW'(1);
        end else if (push_i) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                do_push = 1'b1;
                ptr_d   = ptr_q + PW'(1);
            end
        end
        empty_d = (ptr_d == '0);
        full_d  = (ptr_d == PTR_FULL);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Entry storage needs no reset: the pointer alone defines validity.
    always_ff @(posedge clk_i) begin
        if (!reset_i && do_push) mem_q[ptr_q[IW-1:0]] <= push_data_i;
    end

    assign top_idx = ptr_q[IW-1:0] - IW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign err_o   = err_q;

endmodule

// File: rtl/pc_counter16.sv
// Hack-style 16-bit program counter; the return-address stack and call/ret
// behaviour are built only when PC_CALL_STACK_EN is defined.
module pc_counter16
    import pc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] in_i,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic        stall_i,
    input  logic        call_i,
    input  logic        ret_i,
    output logic [15:0] out_o,
    output logic        stk_empty_o,
    output logic        stk_full_o,
    output logic        stk_err_o
);
    addr_t    pc_q, pc_d;
    addr_t    pc_inc;
    nxt_sel_e sel;
    addr_t    stk_top;
    logic     stk_empty, stk_full, stk_err;

    // Single incrementer shared by the inc path and the call return address.
    Inc16 u_inc (
        .in  (pc_q),
        .out (pc_inc)
    );

    always_comb begin
        sel = NXT_HOLD;
        if (stall_i)     sel = NXT_HOLD;
`ifdef PC_CALL_STACK_EN
        else if (ret_i)  sel = NXT_RET;
        else if (call_i) sel = NXT_CALL;
`else
        else if (call_i) sel = NXT_LOAD;
`endif
        else if (load_i) sel = NXT_LOAD;
        else if (inc_i)  sel = NXT_INC;
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            NXT_INC:  pc_d = pc_inc;
            NXT_LOAD: pc_d = in_i;
            NXT_CALL: pc_d = in_i;
            NXT_RET:  pc_d = stk_empty ? pc_q : stk_top;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) pc_q <= PC_RESET_ADDR;
        else         pc_q <= pc_d;
    end

`ifdef PC_CALL_STACK_EN
    pc_ret_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (sel == NXT_CALL),
        .pop_i       (sel == NXT_RET),
        .push_data_i (pc_inc),
        .top_o       (stk_top),
        .empty_o     (stk_empty),
        .full_o      (stk_full),
        .err_o       (stk_err)
    );
`else
    localparam int UNUSED_DEPTH = DEPTH;
    logic unused_ret;
    assign unused_ret = ret_i;
    assign stk_top    = PC_RESET_ADDR;
    assign stk_empty  = 1'b1;
    assign stk_full   = 1'b0;
    assign stk_err    = 1'b0;
`endif

    assign out_o       = pc_q;
    assign stk_empty_o = stk_empty;
    assign stk_full_o  = stk_full;
    assign stk_err_o   = stk_err;

endmodule

// File: tb/tb_pc_counter16.sv
// Self-checking bench for pc_counter16; expectations follow PC_CALL_STACK_EN.
module tb_pc_counter16;

`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        load = 1'b0, inc = 1'b0, stall = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] out;
    logic        stk_empty, stk_full, stk_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] out;
        logic        emp;
        logic        full;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        rst, ld, ic, st;
        logic [15:0] din;
        logic [15:0] eout;
    } vec_t;

    pc_counter16 #(.DEPTH(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_i        (din),
        .load_i      (load),
        .inc_i       (inc),
        .stall_i     (stall),
        .call_i      (call),
        .ret_i       (ret),
        .out_o       (out),
        .stk_empty_o (stk_empty),
        .stk_full_o  (stk_full),
        .stk_err_o   (stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm);
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
            return;
        end
        e = sb_q.pop_front();
        if (out !== e.out) begin
            n_fail++;
            $display("FAIL %s out: got %h expected %h", nm, out, e.out);
        end
        n_tests++;
        if ({stk_empty, stk_full, stk_err} !== {e.emp, e.full, e.err}) begin
            n_fail++;
            $display("FAIL %s flags(empty,full,err): got %b%b%b expected %b%b%b",
                     nm, stk_empty, stk_full, stk_err, e.emp, e.full, e.err);
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then check.
    task automatic step(input logic rst, ld, ic, st, cl, rt, input logic [15:0] d,
                        input logic [15:0] eo, input logic ee, ef, er, input string nm);
        exp_t e;
        reset = rst; load = ld; inc = ic; stall = st; call = cl; ret = rt; din = d;
        if (!STK) begin ee = 1'b1; ef = 1'b0; er = 1'b0; end
        e = '{out: eo, emp: ee, full: ef, err: er};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic [15:0] tgt;
        logic [15:0] entry [8];

        // rst ld ic st din exp_out
        vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0001});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0002});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0003});
        vecs.push_back('{0, 1, 0, 0, 16'h1234, 16'h1234});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h1235});
        vecs.push_back('{0, 1, 1, 0, 16'h1234, 16'h1234});
        vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h1234});
        vecs.push_back('{0, 1, 0, 1, 16'h5555, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h9999, 16'h1234});
        vecs.push_back('{0, 1, 0, 0, 16'hFFFF, 16'hFFFF});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000});
        vecs.push_back('{0, 1, 0, 0, 16'h7777, 16'h7777});
        vecs.push_back('{1, 1, 1, 0, 16'h4321, 16'h0000});

        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].ic, vecs[i].st, 1'b0, 1'b0,
                 vecs[i].din, vecs[i].eout, 1'b1, 1'b0, 1'b0, $sformatf("vec[%0d]", i));
        end

        // Call from 0xFFFF pushes 0x0000, then return.
        step(0, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0, "a_load");
        step(0, 0, 0, 0, 1, 0, 16'h0100, 16'h0100, 0, 0, 0, "a_call");
        step(0, 0, 0, 0, 0, 1, 16'h0000, STK ? 16'h0000 : 16'h0100, 1, 0, 0, "a_ret");

        // Nested calls with a stalled ret in between.
        step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "b_reset");
        step(0, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0, "b_load");
        step(0, 0, 0, 0, 1, 0, 16'h0200, 16'h0200, 0, 0, 0, "b_call1");
        step(0, 0, 0, 0, 1, 0, 16'h0300, 16'h0300, 0, 0, 0, "b_call2");
        step(0, 0, 1, 1, 0, 1, 16'h0000, 16'h0300, 0, 0, 0, "b_stall_ret");
        step(0, 0, 0, 0, 0, 1, 16'h0000, STK ? 16'h0201 : 16'h0300, 0, 0, 0, "b_ret1");
        step(0, 0, 0, 0, 0, 1, 16'h0000, STK ? 16'h0011 : 16'h0300, 1, 0, 0, "b_ret2");

        // Overflow: 9 calls into an 8-deep stack, then unwind and underflow.
        step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "c_reset");
        step(0, 1, 0, 0, 0, 0, 16'h1000, 16'h1000, 1, 0, 0, "c_load");
        entry[0] = 16'h1001;
        for (int i = 0; i < 9; i++) begin
            tgt = 16'h2000 + 16'(i * 16);
            if (i > 0 && i < 8) entry[i] = 16'h2000 + 16'((i - 1) * 16) + 16'h0001;
            step(0, 0, 0, 0, 1, 0, tgt, tgt, 0, (i >= 7), (i == 8),
                 $sformatf("c_call%0d", i));
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 0, 1, 16'h0000, STK ? entry[7 - k] : 16'h2080,
                 (k == 7), 0, 1, $sformatf("c_ret%0d", k));
        end
        step(0, 0, 0, 0, 0, 1, 16'h0000, STK ? 16'h1001 : 16'h2080, 1, 0, 1, "c_ret_under");
        step(0, 0, 0, 0, 1, 1, 16'h4444, STK ? 16'h1001 : 16'h4444, 1, 0, 1, "c_call_ret");

        // Reset in the middle of a call sequence discards the stack.
        step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "d_reset0");
        step(0, 0, 0, 0, 1, 0, 16'h0A00, 16'h0A00, 0, 0, 0, "d_call1");
        step(0, 0, 0, 0, 1, 0, 16'h0B00, 16'h0B00, 0, 0, 0, "d_call2");
        step(0, 0, 0, 0, 1, 0, 16'h0C00, 16'h0C00, 0, 0, 0, "d_call3");
        step(1, 0, 0, 0, 1, 0, 16'h0D00, 16'h0000, 1, 0, 0, "d_reset1");
        step(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1, "d_ret_under");
        step(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 1, "d_inc_err_sticky");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_counter16.md
# pc_counter16

Hack-style 16-bit program counter with an optional hardware return-address stack. Each cycle it selects the next instruction address: the current address incremented, a jump target, a return address, or the current value held. It sits directly downstream of the 16-bit incrementer, which produces `out + 1`, and directly upstream of instruction-memory addressing.

## Interface
- `DEPTH`, 8: return-stack entries; power of two, 2..64; used only with the stack compiled in.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  16  jump/call target address.
- `load`  in  1  jump: next `out` = `in`.
- `inc`  in  1  advance: next `out` = `out + 1` (mod 2^16).
- `stall`  in  1  freeze `out` and the stack this cycle.
- `call`  in  1  push `out + 1`, next `out` = `in`.
- `ret`  in  1  pop top of stack into `out`.
- `out`  out  16  current instruction address (registered).
- `stk_empty`  out  1  stack holds 0 entries.
- `stk_full`  out  1  stack holds `DEPTH` entries.
- `stk_err`  out  1  sticky overflow/underflow flag.

## Operation
- Priority, highest first: reset > stall > ret > call > load > inc > hold.
- reset: `out` = 0x0000, stack pointer = 0, `stk_err` = 0. Stack RAM contents are don't-care.
- stall: all state is unchanged, whatever the other inputs are.
- ret, stack non-empty: `out` = top entry, pointer − 1.
- ret, stack empty (underflow): `out` holds, pointer stays 0, `stk_err` = 1.
- call, stack not full: entry[ptr] = `out + 1` (mod 2^16), pointer + 1, `out` = `in`.
- call, stack full (overflow): jump still taken (`out` = `in`), push dropped, pointer stays `DEPTH`, `stk_err` = 1.
- load: `out` = `in`; stack untouched.
- inc: `out` = `out + 1`; 0xFFFF wraps to 0x0000 with no flag.
- No input asserted: `out` holds.
- `out + 1` is taken from one incrementer instance and shared by the inc and call paths. A call from 0xFFFF pushes 0x0000.
- `stk_err` clears only on reset.

## Timing
- Every `out` change is visible one cycle after the qualifying edge. There is no combinational path from inputs to `out`.
- Reset values: `out` = 0x0000, `stk_empty` = 1, `stk_full` = 0, `stk_err` = 0.
- `stk_empty`, `stk_full` and `stk_err` are registered and update on the same edge as the operation that changes them.
- Back-to-back call/ret on consecutive cycles is supported at full rate.
- If call and ret are asserted together, ret wins; call is ignored and no push occurs.
- If reset is asserted during a call/ret sequence, the stack is discarded and execution restarts at 0x0000 on the next edge.

## Configuration
- `PC_CALL_STACK_EN` defined: return stack, `call`/`ret` behaviour and status flags work as described above.
- `PC_CALL_STACK_EN` undefined:
  - no stack storage is built;
  - `call` behaves as `load`;
  - `ret` is ignored;
  - `stk_empty` = 1, `stk_full` = 0 and `stk_err` = 0 constantly;
  - `DEPTH` is unused;
  - port list is identical in both builds.

## Structure
- Shared package `pc_pkg` holds:
  - `addr_t` (16-bit address type);
  - `PC_RESET_ADDR` = 16'h0000;
  - an enum for the selected next-address source: `NXT_HOLD`, `NXT_INC`, `NXT_LOAD`, `NXT_CALL`, `NXT_RET`.
- The incrementer is reused as the existing `Inc16` instance.
- One new sub-module, `pc_ret_stack`, contains:
  - `DEPTH` × 16 register file;
  - pointer of `$clog2(DEPTH)+1` bits;
  - push/pop inputs, top output, empty/full flags, and the sticky error flag;
  - synchronous reset.
- The sub-module is instantiated only under `PC_CALL_STACK_EN`.

## Test plan
- Reset then inc for 3 cycles -> `out` = 0x0000, 0x0001, 0x0002, 0x0003; `stk_empty` = 1.
- `in` = 0x1234 with load, then inc -> 0x1234, 0x1235. Load and inc together -> 0x1234 (load wins). Stall with inc -> value held.
- load 0xFFFF then inc -> 0x0000, `stk_err` = 0. call with `in` = 0x0100 from 0xFFFF, then ret -> 0x0100, then 0x0000.
- From 0x0010, call 0x0200 and then call 0x0300 from 0x0200 -> after two rets, `out` = 0x0201, then 0x0011, and `stk_empty` = 1.
- `DEPTH` = 8: 9 consecutive calls -> `stk_full` = 1 after the 8th call; 9th jump taken, `stk_err` = 1. Then 8 rets unwind correctly, and a 9th ret holds `out` with `stk_err` still 1.
- 3 calls, then reset -> `out` = 0x0000, `stk_empty` = 1, `stk_err` = 0; a following ret holds 0x0000 and sets `stk_err`. The macro-undefined build repeats this scenario with call acting as load and all flags constant.
